divider_seq_responder: RTL and testbench
========================================

Name: divider_seq_responder

Overview:
- Multicycle unsigned integer divider: responder side of the execute-stage valid/done handshake used by the ALU for DIV/DIVU/REM/REMU and their W variants.
- The ALU holds `valid` and the operands steady while it stalls; this block iterates a restoring shift-subtract loop and returns {remainder, quotient} with a one-cycle `done`.
- Sign handling, W-variant truncation and divide-by-zero substitution stay in the ALU; this block sees unsigned operands only.

Parameters:
WIDTH, 64, operand width in bits.
BITS_PER_CYCLE, 1, quotient bits retired per cycle. Legal values are 1, 2 and 4, and the value must divide WIDTH.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  reset, asynchronous and active-high.
valid  input  1  request, held high by the initiator until it sees `done`.
a  input  WIDTH  dividend, unsigned.
b  input  WIDTH  divisor, unsigned.
done  output  1  result valid, high for exactly one cycle per completed operation.
res  output  2*WIDTH  result: {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; count, remainder and quotient registers cleared.
  - done=0, res=0.
  - Reset asserted mid-operation discards the operation immediately; no `done` follows.
- State machine IDLE/BUSY/DONE; `done` = (state==DONE), decoded from registered state, not from inputs.
- IDLE:
  - valid=1 at a clock edge: capture a into the dividend shift register and b into the divisor register, clear the partial remainder, set count=0, go to BUSY.
  - valid=0: stay in IDLE.
- BUSY:
  - Each cycle performs BITS_PER_CYCLE restoring steps, chained combinationally:
    - R' = {R[WIDTH-1:0], next dividend MSB} at WIDTH+1 bits.
    - If R' >= divisor: R = R' - divisor and the quotient bit is 1.
    - Otherwise: R = R' and the quotient bit is 0.
  - Quotient bits shift in at the LSB.
  - count increments by 1 per cycle. When count reaches WIDTH/BITS_PER_CYCLE-1, the last steps complete and the FSM moves to DONE.
- Latency: the first `done` cycle is exactly WIDTH/BITS_PER_CYCLE+1 cycles after the capturing edge (65 cycles for the defaults).
- DONE:
  - res is driven from the final registers and held stable for that cycle; it keeps the same value afterwards until the next DONE.
  - The FSM always returns to IDLE on the next edge.
  - If valid is still high in that IDLE cycle (next instruction is also a divide), the new operands are captured there. No operation is ever started from the DONE state itself.
- Abort: valid=0 during BUSY (pipeline flush) returns the FSM to IDLE at the next edge. No `done` is produced and res is unchanged.
- Operands are sampled only at capture; changes to a/b during BUSY are ignored.
- Divide by zero is not special-cased; the natural restoring result is required: quotient = all ones, remainder = a.
- Arithmetic:
  - All arithmetic is unsigned.
  - The compare/subtract is done at WIDTH+1 bits so the shifted remainder never overflows.
  - Remainder is always less than the divisor when b != 0.
- `done` never asserts unless valid was high at the capturing edge and stayed high through every BUSY cycle.

Test Plan:
- a=100, b=7 with valid held high → done exactly 65 cycles after the capture edge; res={64'd2, 64'd14}; done low the following cycle.
- a=64'hFFFF_FFFF_FFFF_FFFF, b=1 → quotient=64'hFFFF_FFFF_FFFF_FFFF, remainder=0. Same a with b=64'hFFFF_FFFF_FFFF_FFFF → quotient=1, remainder=0.
- a=5, b=0 → quotient=64'hFFFF_FFFF_FFFF_FFFF, remainder=5, latency unchanged.
- Back-to-back:
  - valid stays high across done; operands switch to a=9, b=4 on the done cycle.
  - The second op is captured on the edge after done, and second done arrives 65 cycles later with res={1, 2}.
  - Check that a/b changes during BUSY have no effect on either result.
- Abort and reset:
  - Drop valid at BUSY cycle 20 → no done; then a new op a=50, b=5 yields {0, 10} with full latency.
  - Assert reset asynchronously (between clock edges) at cycle 30 of an op → done=0 and res=0 immediately.
- With BITS_PER_CYCLE=4 → a=1000, b=33 gives {10, 30}, with done exactly 17 cycles after capture.

Source files
------------

// File: rtl/divider_seq_responder_if.sv
// Execute-stage valid/done handshake between the ALU (master) and the
// multicycle divider (slave).
interface divider_seq_responder_if #(
  parameter int WIDTH = 64
);
  logic               valid;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               done;
  logic [2*WIDTH-1:0] res;

  modport master (output valid, a, b, input done, res);
  modport slave  (input valid, a, b, output done, res);
endinterface

// File: rtl/divider_seq_responder.sv
// Multicycle unsigned restoring divider retiring BITS_PER_CYCLE quotient bits
// per cycle; returns {remainder, quotient} with a one-cycle done pulse.
module divider_seq_responder #(
  parameter int WIDTH          = 64,
  parameter int BITS_PER_CYCLE = 1   // 1, 2 or 4, and must divide WIDTH
) (
  input logic                    clk,
  input logic                    reset,
  divider_seq_responder_if.slave bus
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   rem;       // partial remainder
  logic [WIDTH-1:0]   dq;        // dividend shifts out at MSB, quotient in at LSB
  logic [WIDTH-1:0]   divisor;
  logic [2*WIDTH-1:0] res_q;

  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   dq_next;
  logic [WIDTH:0]     shifted;
  logic               ge;

  // Chain BITS_PER_CYCLE restoring steps combinationally. The compare uses
  // the full WIDTH+1 shifted value; the subtract can stay WIDTH bits because
  // the true difference is always below the divisor.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rem_next = rem;
    dq_next  = dq;
    shifted  = '0;
    ge       = 1'b0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      shifted  = {rem_next, dq_next[WIDTH-1]};
      ge       = (shifted >= {1'b0, divisor});
      dq_next  = {dq_next[WIDTH-2:0], ge};
      rem_next = ge ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      rem     <= '0;
      dq      <= '0;
      divisor <= '0;
      res_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid) begin
            dq      <= bus.a;
            divisor <= bus.b;
            rem     <= '0;
            count   <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (!bus.valid) begin
            // Pipeline flush: drop the operation, keep the last result.
            state <= IDLE;
          end else begin
            rem   <= rem_next;
            dq    <= dq_next;
            count <= count + CNT_W'(1);
            if (count == LAST) begin
              res_q <= {rem_next, dq_next};
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.done = (state == DONE);
  assign bus.res  = res_q;

endmodule

// File: tb/tb_divider_seq_responder.sv
// Scoreboard bench for divider_seq_responder: one instance at 1 bit/cycle and
// one at 4 bits/cycle, expected results from a behavioural / and % model.
module tb_divider_seq_responder;

  localparam int W = 64;

  typedef struct {
    logic [2*W-1:0] res;
    int             cap;
    int             lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;

  exp_t q0[$];
  exp_t q4[$];
  logic prev_done0 = 1'b0;
  logic prev_done4 = 1'b0;

  divider_seq_responder_if #(.WIDTH(W)) bus0 ();
  divider_seq_responder_if #(.WIDTH(W)) bus4 ();

  divider_seq_responder #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  divider_seq_responder #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [2*W-1:0] got,
                       input logic [2*W-1:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    if (b == '0) return {a, {W{1'b1}}};
    return {a % b, a / b};
  endfunction

  // Called at a negedge; the following posedge is the capture edge.
  task automatic start(input bit sel, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit track);
    exp_t e;
    e.res = model(a, b);
    e.cap = cyc + 1;
    e.lat = sel ? 17 : 65;
    if (!sel) begin
      bus0.a = a; bus0.b = b; bus0.valid = 1'b1;
      if (track) q0.push_back(e);
    end else begin
      bus4.a = a; bus4.b = b; bus4.valid = 1'b1;
      if (track) q4.push_back(e);
    end
  endtask

  function automatic int qsize(input bit sel);
    return sel ? q4.size() : q0.size();
  endfunction

  // Wait for all tracked results, then drop valid in the IDLE cycle after done.
  task automatic wait_drain(input bit sel, input int budget);
    int n = 0;
    while (qsize(sel) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (qsize(sel) != 0) begin
      check(sel ? "timeout4" : "timeout0", 128'(qsize(sel)), '0);
      if (sel) q4.delete(); else q0.delete();
    end
    #1;
    if (sel) bus4.valid = 1'b0; else bus0.valid = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (prev_done0) check("done_pulse0", 128'(bus0.done), '0);
      if (bus0.done) begin
        if (q0.size() == 0) check("spurious_done0", 128'(1), '0);
        else begin
          e = q0.pop_front();
          check("res0", bus0.res, e.res);
          check("lat0", 128'(cyc + 1 - e.cap), 128'(e.lat));
        end
      end
      prev_done0 <= bus0.done;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (prev_done4) check("done_pulse4", 128'(bus4.done), '0);
      if (bus4.done) begin
        if (q4.size() == 0) check("spurious_done4", 128'(1), '0);
        else begin
          e = q4.pop_front();
          check("res4", bus4.res, e.res);
          check("lat4", 128'(cyc + 1 - e.cap), 128'(e.lat));
        end
      end
      prev_done4 <= bus4.done;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    reset = 1'b1;
    bus0.valid = 1'b0; bus0.a = '0; bus0.b = '0;
    bus4.valid = 1'b0; bus4.a = '0; bus4.b = '0;
    repeat (3) @(negedge clk);
    check("rst_done0", 128'(bus0.done), '0);
    check("rst_res0", bus0.res, '0);
    check("rst_done4", 128'(bus4.done), '0);
    check("rst_res4", bus4.res, '0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single operations including extremes and divide by zero.
    start(0, 64'd100, 64'd7, 1);
    wait_drain(0, 200);
    start(0, '1, 64'd1, 1);
    wait_drain(0, 200);
    start(0, '1, '1, 1);
    wait_drain(0, 200);
    start(0, 64'd5, 64'd0, 1);
    wait_drain(0, 200);

    // Back-to-back with operand changes while busy.
    begin
      int n = 0;
      start(0, 64'd77, 64'd5, 1);
      repeat (10) @(negedge clk);
      bus0.a = 64'hDEAD_BEEF_0123_4567; bus0.b = 64'd3;
      while (!bus0.done && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("b2b_done_seen", 128'(bus0.done), 128'(1));
      bus0.a = 64'd9; bus0.b = 64'd4;
      q0.push_back('{model(64'd9, 64'd4), cyc + 2, 65});
      repeat (10) @(negedge clk);
      bus0.a = 64'hFFFF_0000_FFFF_0000; bus0.b = 64'd11;
      wait_drain(0, 200);
    end

    // Abort during BUSY: no done, previous result held.
    start(0, 64'd123, 64'd4, 0);
    repeat (20) @(negedge clk);
    bus0.valid = 1'b0;
    repeat (80) @(negedge clk);
    check("abort_res", bus0.res, {64'd1, 64'd2});
    check("abort_done", 128'(bus0.done), '0);
    start(0, 64'd50, 64'd5, 1);
    wait_drain(0, 200);

    // Asynchronous reset mid-operation.
    start(0, 64'd1234, 64'd7, 0);
    repeat (30) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("areset_done", 128'(bus0.done), '0);
    check("areset_res", bus0.res, '0);
    @(negedge clk);
    bus0.valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (70) @(negedge clk);
    check("post_reset_done", 128'(bus0.done), '0);
    check("post_reset_res", bus0.res, '0);

    // Four bits per cycle.
    start(1, 64'd1000, 64'd33, 1);
    wait_drain(1, 60);
    start(1, 64'd42, 64'd0, 1);
    wait_drain(1, 60);
    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom};
      rb = (i % 2 == 0) ? 64'($urandom_range(1, 1000)) : {32'($urandom_range(0, 3)), $urandom};
      start(1, ra, rb, 1);
      wait_drain(1, 60);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
